vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_BP, default 48: pixel ticks from the hsync rising edge to the first active pixel.
REQ-002 SHALL have parameter V_BP, default 33: lines from the vsync rising edge to the first active line.
REQ-003 SHALL have parameters WIN_X 0, WIN_Y 0, WIN_W 200, WIN_H 100: the capture window in active-pixel coordinates.
REQ-004 SHALL have port clk_50MHz, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port pix_en, input, 1: pixel-tick strobe; one clk_50MHz cycle in two at 25 MHz.
REQ-007 SHALL have ports hsync and vsync, input, 1 each: active-low syncs, asynchronous to the block.
REQ-008 SHALL have port rgb, input, 6: pixel data.
REQ-009 SHALL have port cap_req, input, 1: single-cycle capture request.
REQ-010 SHALL have ports cap_busy, cap_done and overrun, output, 1 each: status outputs.
REQ-011 SHALL have ports wr_en (output, 1), wr_addr (output, 16) and wr_data (output, 6): the frame-buffer write port.
REQ-012 SHALL have ports h_total and v_total, output, 10 each: measured timing.

Function
REQ-013 SHALL pass hsync, vsync, rgb and pix_en through the same 2-stage register chain; all decisions use stage-2 values.
REQ-014 SHALL treat a sync rising edge as stage-2 high while the previous stage-2 value was low.
REQ-015 SHALL, on each stage-2 pix_en, increment hcnt (10 bit, saturating at 1023).
REQ-016 SHALL clear hcnt to 0 on an hsync rising edge, overriding the increment.
REQ-017 SHALL increment vcnt (10 bit, saturating at 1023) on each hsync rising edge and clear it on a vsync rising edge; a simultaneous vsync edge wins.
REQ-018 SHALL compute x = hcnt-H_BP and y = vcnt-V_BP.
REQ-019 SHALL declare a pixel in-window when hcnt>=H_BP and vcnt>=V_BP and WIN_X<=x<WIN_X+WIN_W and WIN_Y<=y<WIN_Y+WIN_H.
REQ-020 SHALL implement the state machine IDLE, ARMED, CAPTURE.
REQ-021 SHALL move IDLE->ARMED on cap_req and ignore cap_req in any other state.
REQ-022 SHALL move ARMED->CAPTURE on a vsync rising edge.
REQ-023 SHALL, in CAPTURE, register wr_en=1, wr_data=stage-2 rgb and wr_addr=pointer one cycle after each in-window stage-2 pix_en cycle, then increment the pointer; this gives 3 clk_50MHz latency from the input pins to the write.
REQ-024 SHALL clear the pointer to 0 on entry to CAPTURE.
REQ-025 SHALL return CAPTURE->IDLE and pulse cap_done for 1 cycle in the cycle of the write at address WIN_W*WIN_H-1.
REQ-026 SHALL, if a vsync rising edge occurs in CAPTURE before the last write, set sticky overrun, pulse cap_done and go to IDLE with no further writes.
REQ-027 SHALL clear overrun on an accepted cap_req.
REQ-028 SHALL drive cap_busy=1 exactly in ARMED and CAPTURE.
REQ-029 SHALL hold wr_en at 0 outside CAPTURE; wr_addr and wr_data hold their last value when wr_en=0.

Reset
REQ-030 SHALL, on rst low, asynchronously clear all registers: state IDLE; hcnt, vcnt, pointer, wr_en, wr_addr, wr_data, cap_busy, cap_done, overrun, h_total, v_total all 0; sync stages 1.
REQ-031 SHALL abort an in-progress capture on mid-capture reset without raising cap_done, and restart a capture only on a new cap_req.

Configuration
REQ-032 SHALL, with VGA_CAP_MEASURE_EN defined, latch h_total = hcnt+1 at each hsync rising edge (pixel ticks per line).
REQ-033 SHALL, with VGA_CAP_MEASURE_EN defined, latch v_total = vcnt+1 at each vsync rising edge (lines per frame).
REQ-034 SHALL, with VGA_CAP_MEASURE_EN undefined, tie h_total and v_total to 0 and build no measurement registers.

Verification
REQ-035 SHALL cover: standard 640x480 source (800x525), cap_req pulse -> exactly 20000 wr_en pulses, addresses 0..19999, first write = first back-porch-aligned active pixel, cap_done once, overrun 0.
REQ-036 SHALL cover: WIN_X=10, WIN_Y=5 with rgb = x[5:0] -> wr_addr 0 data 10; wr_addr 200 is the first pixel of line y=6.
REQ-037 SHALL cover: source cut to 120 active lines, WIN_H=200 -> overrun=1, cap_done pulse at the next vsync edge, fewer than WIN_W*WIN_H writes; the next cap_req clears overrun.
REQ-038 SHALL cover: cap_req repeated during ARMED and CAPTURE -> ignored; a single capture completes.
REQ-039 SHALL cover: rst low mid-CAPTURE -> all outputs 0 within the same cycle, no cap_done; with the macro, h_total=800 and v_total=525 after two frames.

Source files
------------

// File: rtl/vga_capture.sv
// VGA frame grabber: syncs an external 640x480-style source, counts pixels/lines and writes a window into a frame buffer.
// Define VGA_CAP_MEASURE_EN to build the h_total/v_total line/frame measurement registers.
module vga_capture #(
  parameter int H_BP  = 48,
  parameter int V_BP  = 33,
  parameter int WIN_X = 0,
  parameter int WIN_Y = 0,
  parameter int WIN_W = 200,
  parameter int WIN_H = 100
) (
  input  logic        clk_50MHz,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rgb,
  input  logic        cap_req,
  output logic        cap_busy,
  output logic        cap_done,
  output logic        overrun,
  output logic        wr_en,
  output logic [15:0] wr_addr,
  output logic [5:0]  wr_data,
  output logic [9:0]  h_total,
  output logic [9:0]  v_total
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;

  localparam logic [11:0] HBP12 = 12'(H_BP);
  localparam logic [11:0] VBP12 = 12'(V_BP);
  localparam logic [11:0] WX12  = 12'(WIN_X);
  localparam logic [11:0] WY12  = 12'(WIN_Y);
  localparam logic [11:0] WW12  = 12'(WIN_W);
  localparam logic [11:0] WH12  = 12'(WIN_H);
  localparam logic [15:0] LAST_ADDR = 16'(WIN_W * WIN_H - 1);

  // Two-stage input chain plus one extra sync bit for edge detection
  logic       hs1_q, hs2_q, hs3_q;
  logic       vs1_q, vs2_q, vs3_q;
  logic       pe1_q, pe2_q;
  logic [5:0] rgb1_q, rgb2_q;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      hs1_q  <= 1'b1;
      hs2_q  <= 1'b1;
      hs3_q  <= 1'b1;
      vs1_q  <= 1'b1;
      vs2_q  <= 1'b1;
      vs3_q  <= 1'b1;
      pe1_q  <= 1'b0;
      pe2_q  <= 1'b0;
      rgb1_q <= '0;
      rgb2_q <= '0;
    end else begin
      hs1_q  <= hsync;
      hs2_q  <= hs1_q;
      hs3_q  <= hs2_q;
      vs1_q  <= vsync;
      vs2_q  <= vs1_q;
      vs3_q  <= vs2_q;
      pe1_q  <= pix_en;
      pe2_q  <= pe1_q;
      rgb1_q <= rgb;
      rgb2_q <= rgb1_q;
    end
  end

  logic hs_rise, vs_rise;
  assign hs_rise = hs2_q & ~hs3_q;
  assign vs_rise = vs2_q & ~vs3_q;

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;

  always_comb begin
    hcnt_d = hcnt_q;
    if (hs_rise)
      hcnt_d = '0;
    else if (pe2_q && (hcnt_q != '1))
      hcnt_d = hcnt_q + 10'd1;

    vcnt_d = vcnt_q;
    if (vs_rise)
      vcnt_d = '0;
    else if (hs_rise && (vcnt_q != '1))
      vcnt_d = vcnt_q + 10'd1;
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // 12-bit differences: bit 11 set means the counter is still inside the back porch,
  // and a window-relative offset below zero wraps far above any window size.
  logic [11:0] hx, vy, xw, yw;
  logic        in_win;

  assign hx = {2'b00, hcnt_q} - HBP12;
  assign vy = {2'b00, vcnt_q} - VBP12;
  assign xw = hx - WX12;
  assign yw = vy - WY12;
  assign in_win = ~hx[11] & ~vy[11] & (xw < WW12) & (yw < WH12);

  logic        pix_hit;
  assign pix_hit = pe2_q & in_win;

  logic [1:0]  state_q, state_d;
  logic [15:0] ptr_q, ptr_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [5:0]  wr_data_q, wr_data_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    ovr_d     = ovr_q;
    case (state_q)
      ST_IDLE: begin
        if (cap_req) begin
          state_d = ST_ARMED;
          ovr_d   = 1'b0;
        end
      end
      ST_ARMED: begin
        if (vs_rise) begin
          state_d = ST_CAPTURE;
          ptr_d   = '0;
        end
      end
      ST_CAPTURE: begin
        // A new frame before the window is full aborts the capture
        if (vs_rise) begin
          ovr_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (pix_hit) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = rgb2_q;
          ptr_d     = ptr_q + 16'd1;
          if (ptr_q == LAST_ADDR) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign cap_busy = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  assign cap_done = done_q;
  assign overrun  = ovr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

`ifdef VGA_CAP_MEASURE_EN
  logic [9:0] h_total_q, v_total_q;

  always_ff @(posedge clk_50MHz or negedge rst) begin
    if (!rst) begin
      h_total_q <= '0;
      v_total_q <= '0;
    end else begin
      if (hs_rise)
        h_total_q <= hcnt_q + 10'd1;
      if (vs_rise)
        v_total_q <= vcnt_q + 10'd1;
    end
  end

  assign h_total = h_total_q;
  assign v_total = v_total_q;
`else
  assign h_total = '0;
  assign v_total = '0;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: a scaled-down VGA source (40x30 ticks/lines) drives three windowed instances.
// Captured writes are compared against window geometry and a per-pixel colour function.
module tb_vga_capture;

  localparam int HBP   = 4;
  localparam int VBP   = 3;
  localparam int LINE  = 40;
  localparam int FRAME = 30;
  localparam int ACT_W = 24;
  localparam int ACT_H = 20;
  localparam int HS_LO = 32;
  localparam int VS_LO = 26;
  localparam int W     = 8;
  localparam int H     = 6;
  localparam int HC    = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, pix_en, hsync, vsync, cap_req;
  logic [5:0] rgb;
  logic [2:0] busy_w, done_w, ovr_w, wen_w;
  logic [15:0] waddr_w [3];
  logic [5:0]  wdata_w [3];
  logic [9:0]  ht_w [3];
  logic [9:0]  vt_w [3];

  vga_capture #(.H_BP(HBP), .V_BP(VBP), .WIN_X(0), .WIN_Y(0), .WIN_W(W), .WIN_H(H)) u_a (
    .clk_50MHz(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .cap_req(cap_req), .cap_busy(busy_w[0]), .cap_done(done_w[0]), .overrun(ovr_w[0]),
    .wr_en(wen_w[0]), .wr_addr(waddr_w[0]), .wr_data(wdata_w[0]), .h_total(ht_w[0]), .v_total(vt_w[0]));

  vga_capture #(.H_BP(HBP), .V_BP(VBP), .WIN_X(10), .WIN_Y(5), .WIN_W(W), .WIN_H(H)) u_b (
    .clk_50MHz(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .cap_req(cap_req), .cap_busy(busy_w[1]), .cap_done(done_w[1]), .overrun(ovr_w[1]),
    .wr_en(wen_w[1]), .wr_addr(waddr_w[1]), .wr_data(wdata_w[1]), .h_total(ht_w[1]), .v_total(vt_w[1]));

  vga_capture #(.H_BP(HBP), .V_BP(VBP), .WIN_X(0), .WIN_Y(0), .WIN_W(W), .WIN_H(HC)) u_c (
    .clk_50MHz(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .cap_req(cap_req), .cap_busy(busy_w[2]), .cap_done(done_w[2]), .overrun(ovr_w[2]),
    .wr_en(wen_w[2]), .wr_addr(waddr_w[2]), .wr_data(wdata_w[2]), .h_total(ht_w[2]), .v_total(vt_w[2]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cur_x = -100, cur_y = -100, prev_x = -100, prev_y = -100;
  int cur_cyc = 0, prev_cyc = 0, frame_cyc = 0;
  int salt = 0, mode = 0, rst_base = 0;

  int wn [3] = '{0, 0, 0};
  int dn [3] = '{0, 0, 0};
  int dcyc [3] = '{0, 0, 0};
  int lastw [3] = '{0, 0, 0};
  int wa [3][1024];
  int wd [3][1024];
  int wp [3][1024];
  int wl [3][1024];

  // Each write is tagged with the source pixel one tick back and its pin-to-write latency
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (wen_w[i]) begin
        if (wn[i] < 1024) begin
          wa[i][wn[i]] <= int'(waddr_w[i]);
          wd[i][wn[i]] <= int'(wdata_w[i]);
          wp[i][wn[i]] <= prev_x * 256 + prev_y;
          wl[i][wn[i]] <= cyc - prev_cyc;
        end
        wn[i]    <= wn[i] + 1;
        lastw[i] <= cyc;
      end
      if (done_w[i]) begin
        dn[i]   <= dn[i] + 1;
        dcyc[i] <= cyc;
      end
    end
  end

  function automatic logic [5:0] pix(input int x, input int y, input int s);
    int v;
    v = x * 37 + y * 11 + s * 5 + (x ^ y);
    return v[5:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input int d, input string nm);
    chk({nm, ".wr_en"},   wen_w[d], 0);
    chk({nm, ".busy"},    busy_w[d], 0);
    chk({nm, ".done"},    done_w[d], 0);
    chk({nm, ".overrun"}, ovr_w[d], 0);
    chk({nm, ".wr_addr"}, waddr_w[d], 0);
    chk({nm, ".wr_data"}, wdata_w[d], 0);
    chk({nm, ".h_total"}, ht_w[d], 0);
    chk({nm, ".v_total"}, vt_w[d], 0);
  endtask

  // Address a of a window maps to pixel (x0 + a%ww, y0 + a/ww); only the first ndata carry checked colour
  task automatic chk_capture(input int d, input string nm, input int base, input int x0, input int y0,
                             input int ww, input int n, input int ndata, input int s);
    for (int a = 0; a < n; a++) begin
      int k, x, y;
      logic [5:0] e;
      k = base + a;
      x = x0 + a % ww;
      y = y0 + a / ww;
      e = (mode == 1) ? 6'(x) : pix(x, y, s);
      chk($sformatf("%s.addr[%0d]", nm, a), wa[d][k], a);
      chk($sformatf("%s.latency[%0d]", nm, a), wl[d][k], 3);
      if (a < ndata) begin
        chk($sformatf("%s.data[%0d]", nm, a), wd[d][k], e);
        chk($sformatf("%s.pos[%0d]", nm, a), wp[d][k], x * 256 + y);
      end
    end
  endtask

  task automatic chk_totals(input string nm);
`ifdef VGA_CAP_MEASURE_EN
    chk({nm, ".h_total"}, ht_w[0], LINE);
    chk({nm, ".v_total"}, vt_w[0], FRAME);
`else
    chk({nm, ".h_total"}, ht_w[0], 0);
    chk({nm, ".v_total"}, vt_w[0], 0);
`endif
  endtask

  // hcnt is zeroed on the sync tick itself, so tick t carries hcnt t-1 and video starts at tick HBP+1
  task automatic run_frame(input int rq1, input int rq2, input int rst_ln);
    salt = int'($urandom_range(0, 63));
    for (int l = 0; l < FRAME; l++) begin
      for (int t = 0; t < LINE; t++) begin
        @(posedge clk);
        #1;
        if (l == rst_ln && t == 0) begin
          chk("A.busy_before_rst", busy_w[0], 1);
          rst = 1'b0;
          #1;
          chk_outputs_zero(0, "A_midrst");
          chk("B_midrst.busy", busy_w[1], 0);
          chk("C_midrst.busy", busy_w[2], 0);
          rst_base = wn[0];
        end
        if (l == rst_ln && t == 4) rst = 1'b1;
        prev_x   = cur_x;
        prev_y   = cur_y;
        prev_cyc = cur_cyc;
        cur_x    = t - 1 - HBP;
        cur_y    = l - VBP;
        cur_cyc  = cyc;
        if (l == 0 && t == 0) frame_cyc = cyc;
        hsync = (t < HS_LO);
        vsync = (l < VS_LO);
        if (cur_x >= 0 && cur_x < ACT_W && cur_y >= 0 && cur_y < ACT_H)
          rgb = (mode == 1) ? 6'(cur_x) : pix(cur_x, cur_y, salt);
        else
          rgb = 6'($urandom);
        pix_en  = 1'b1;
        cap_req = (t == 10) && (l == rq1 || l == rq2);
        @(posedge clk);
        #1;
        pix_en  = 1'b0;
        cap_req = 1'b0;
      end
    end
  endtask

  int b [3];
  int db [3];

  initial begin
    rst = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; rgb = '0; cap_req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) chk_outputs_zero(i, $sformatf("rst%0d", i));
    rst = 1'b1;

    run_frame(-1, -1, -1);
    chk("idle.writes", wn[0] + wn[1] + wn[2], 0);
    for (int i = 0; i < 3; i++) begin b[i] = wn[i]; db[i] = dn[i]; end

    // Round 1: request in frame 2 (repeat while armed), repeat again mid-capture in frame 3
    run_frame(10, 20, -1);
    chk("A.armed_busy", busy_w[0], 1);
    chk("A.armed_writes", wn[0] - b[0], 0);
    run_frame(4, -1, -1);
    chk("A.count", wn[0] - b[0], W * H);
    chk("A.done_count", dn[0] - db[0], 1);
    chk("A.done_at_last_write", dcyc[0] - lastw[0], 0);
    chk("A.overrun", ovr_w[0], 0);
    chk("A.busy", busy_w[0], 0);
    chk_capture(0, "A", b[0], 0, 0, W, W * H, W * H, salt);
    chk("B.count", wn[1] - b[1], W * H);
    chk("B.done_count", dn[1] - db[1], 1);
    chk_capture(1, "B", b[1], 10, 5, W, W * H, W * H, salt);
    chk("C.busy_pending", busy_w[2], 1);
    chk("C.done_pending", dn[2] - db[2], 0);
    chk("C.count_frame", wn[2] - b[2], W * (FRAME - VBP));
    chk_capture(2, "C", b[2], 0, 0, W, W * (FRAME - VBP), W * ACT_H, salt);
    chk_totals("steady");

    run_frame(-1, -1, -1);
    chk("C.done_count", dn[2] - db[2], 1);
    chk("C.done_at_vsync", dcyc[2] - frame_cyc, 3);
    chk("C.overrun", ovr_w[2], 1);
    chk("C.busy", busy_w[2], 0);
    chk("C.count_after", wn[2] - b[2], W * (FRAME - VBP));
    chk("A.no_write_idle", wn[0] - b[0], W * H);

    // Round 2: rgb carries x, so data reveals which column was written
    run_frame(10, -1, -1);
    chk("C.overrun_cleared", ovr_w[2], 0);
    chk("C.rearmed", busy_w[2], 1);
    mode = 1;
    for (int i = 0; i < 3; i++) begin b[i] = wn[i]; db[i] = dn[i]; end
    run_frame(-1, -1, -1);
    chk("B2.count", wn[1] - b[1], W * H);
    chk("B2.addr0_data", wd[1][b[1]], 10);
    chk("B2.addr0_y", wp[1][b[1]] % 256, 5);
    chk("B2.addrW_data", wd[1][b[1] + W], 10);
    chk("B2.addrW_y", wp[1][b[1] + W] % 256, 6);
    chk_capture(1, "B2", b[1], 10, 5, W, W * H, W * H, salt);
    chk("A2.done_count", dn[0] - db[0], 1);
    chk_capture(0, "A2", b[0], 0, 0, W, W * H, W * H, salt);
    mode = 0;
    run_frame(-1, -1, -1);

    // Reset in the middle of A's capture
    run_frame(10, -1, -1);
    for (int i = 0; i < 3; i++) db[i] = dn[i];
    run_frame(-1, -1, 5);
    chk("A.rst_no_done", dn[0] - db[0], 0);
    run_frame(-1, -1, -1);
    run_frame(-1, -1, -1);
    chk("A.rst_no_done_later", dn[0] - db[0], 0);
    chk("A.rst_no_restart", wn[0] - rst_base, 0);
    chk("A.rst_busy", busy_w[0], 0);
    chk("A.rst_overrun", ovr_w[0], 0);
    chk_totals("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
